data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_align.sv | 47 ++++
 rtl/data_mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: access sizes, FSM states,
// and a helper that converts an access size to its byte count.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Byte count of an access; the illegal encoding reports zero.
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane alignment over a two-word window: store data shift, byte enables,
// and load extraction with sign/zero extension.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]          i_lane,
    input  size_e               i_size,
    input  logic                i_unsigned,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [2*WORD_W-1:0] i_rwin,
    output logic [2*LANES-1:0]  o_be_c,
    output logic [2*WORD_W-1:0] o_wwin_c,
    output logic [WORD_W-1:0]   o_rdata_c
);

    logic [2*LANES-1:0] w_mask;
    logic [4:0]         w_shamt;
    logic [WORD_W-1:0]  w_raw;

    always_comb begin
        w_mask = '0;
        case (i_size)
            SZ_BYTE: w_mask = 8'h01;
            SZ_HALF: w_mask = 8'h03;
            SZ_WORD: w_mask = 8'h0F;
            default: w_mask = '0;
        endcase
    end

    assign w_shamt  = {i_lane, 3'b000};
    assign o_be_c   = w_mask << i_lane;
    assign o_wwin_c = {32'b0, i_wdata} << w_shamt;
    assign w_raw    = WORD_W'(i_rwin >> w_shamt);

    always_comb begin
        o_rdata_c = '0;
        case (i_size)
            SZ_BYTE: o_rdata_c = i_unsigned ? {24'b0, w_raw[7:0]}
                                            : {{24{w_raw[7]}}, w_raw[7:0]};
            SZ_HALF: o_rdata_c = i_unsigned ? {16'b0, w_raw[15:0]}
                                            : {{16{w_raw[15]}}, w_raw[15:0]};
            SZ_WORD: o_rdata_c = w_raw;
            default: o_rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access; word-boundary
// crossing accesses are optionally split over two cycles.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS      = 1024,
    parameter int unsigned ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [WORD_W-1:0] r_rsp_rdata;

    // Context of a split access, held for its second cycle
    logic [AW-1:0]     r_hi_idx;
    logic [1:0]        r_lane;
    size_e             r_size;
    logic              r_unsigned;
    logic              r_we;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_lo_word;

    size_e             w_size;
    logic [31:0]       w_idx_ext;
    logic [AW-1:0]     w_idx;
    logic [3:0]        w_span;
    logic              w_cross;
    logic              w_oob;
    logic              w_misal;
    logic              w_fault;
    logic              w_accept;
    logic              w_split;
    logic [WORD_W-1:0] w_rd_lo;
    logic [WORD_W-1:0] w_rd_hi;

    logic [1:0]          w_al_lane;
    size_e               w_al_size;
    logic                w_al_uns;
    logic [WORD_W-1:0]   w_al_wdata;
    logic [2*WORD_W-1:0] w_al_rwin;
    logic [2*LANES-1:0]  w_be;
    logic [2*WORD_W-1:0] w_wwin;
    logic [WORD_W-1:0]   w_rdata;

    logic              w_mem_we;
    logic [AW-1:0]     w_mem_idx;
    logic [LANES-1:0]  w_mem_be;
    logic [WORD_W-1:0] w_mem_wdata;
    logic              w_rsp_valid_d;
    logic              w_rsp_fault_d;
    logic [WORD_W-1:0] w_rsp_rdata_d;
    logic              w_capture;

    // Request decode
    assign w_size    = size_e'(req_size);
    assign w_idx_ext = {2'b00, req_addr[31:2]};
    assign w_idx     = AW'(req_addr[31:2]);
    assign w_span    = {2'b00, req_addr[1:0]} + {1'b0, size_bytes(w_size)};
    assign w_cross   = (w_span > 4'd4);
    assign w_oob     = (w_idx_ext >= DEPTH_WORDS) ||
                       (w_cross && ((w_idx_ext + 32'd1) >= DEPTH_WORDS));
    assign w_misal   = (ALLOW_MISALIGNED == 0) &&
                       (((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));
    assign w_fault   = (w_size == SZ_ILL) || w_oob || w_misal;
    assign w_accept  = req_valid && r_ready && !rst;
    assign w_split   = (r_state == SPLIT);

    assign w_rd_lo = r_mem[w_idx];
    assign w_rd_hi = r_mem[r_hi_idx];

    // Aligner sees the live request in IDLE and the held one in SPLIT
    assign w_al_lane  = w_split ? r_lane     : req_addr[1:0];
    assign w_al_size  = w_split ? r_size     : w_size;
    assign w_al_uns   = w_split ? r_unsigned : req_unsigned;
    assign w_al_wdata = w_split ? r_wdata    : req_wdata;
    assign w_al_rwin  = w_split ? {w_rd_hi, r_lo_word} : {32'b0, w_rd_lo};

    dmem_align u_align (
        .i_lane     (w_al_lane),
        .i_size     (w_al_size),
        .i_unsigned (w_al_uns),
        .i_wdata    (w_al_wdata),
        .i_rwin     (w_al_rwin),
        .o_be_c     (w_be),
        .o_wwin_c   (w_wwin),
        .o_rdata_c  (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_fault && w_cross) w_state_nxt = SPLIT;
            SPLIT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_mem_we      = 1'b0;
        w_mem_idx     = w_idx;
        w_mem_be      = '0;
        w_mem_wdata   = '0;
        w_rsp_valid_d = 1'b0;
        w_rsp_fault_d = 1'b0;
        w_rsp_rdata_d = '0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_rsp_valid_d = 1'b1;
                        w_rsp_fault_d = 1'b1;
                    end else begin
                        w_mem_we      = req_we;
                        w_mem_be      = w_be[3:0];
                        w_mem_wdata   = w_wwin[31:0];
                        w_capture     = w_cross;
                        w_rsp_valid_d = !w_cross;
                        w_rsp_rdata_d = (req_we || w_cross) ? '0 : w_rdata;
                    end
                end
            end
            SPLIT: begin
                if (!rst) begin
                    w_mem_we      = r_we;
                    w_mem_idx     = r_hi_idx;
                    w_mem_be      = w_be[7:4];
                    w_mem_wdata   = w_wwin[63:32];
                    w_rsp_valid_d = 1'b1;
                    w_rsp_rdata_d = r_we ? '0 : w_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_ready     <= (w_state_nxt == IDLE);
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_fault <= w_rsp_fault_d;
            r_rsp_rdata <= w_rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_hi_idx   <= AW'(w_idx_ext + 32'd1);
            r_lane     <= req_addr[1:0];
            r_size     <= w_size;
            r_unsigned <= req_unsigned;
            r_we       <= req_we;
            r_wdata    <= req_wdata;
            r_lo_word  <= w_rd_lo;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_rsp_fault;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one controller with split misaligned access, one with
// misaligned faulting; both share the request stream.
module tb_data_mem_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        ready_a, rsp_valid_a, rsp_fault_a;
    logic [31:0] rsp_rdata_a;
    logic        ready_b, rsp_valid_b, rsp_fault_b;
    logic [31:0] rsp_rdata_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .ALLOW_MISALIGNED(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
        .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a)
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .ALLOW_MISALIGNED(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
        .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!(ready_a && ready_b) && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 8) chk("ready_wait", 32'(ready_a & ready_b), 32'd1);
    endtask

    // One request on both controllers; checks the response of controller 'sel'
    task automatic acc(input int sel, input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_flt, input logic [31:0] exp_rd, input int exp_lat,
                       input logic exp_rdy);
        logic        rdy1;
        logic        vld;
        int          lat;
        wait_ready();
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy1 = (sel == 0) ? ready_a : ready_b;
        vld  = (sel == 0) ? rsp_valid_a : rsp_valid_b;
        lat  = 1;
        while (!vld && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            vld = (sel == 0) ? rsp_valid_a : rsp_valid_b;
        end
        chk({tag, "_rd"},  (sel == 0) ? rsp_rdata_a : rsp_rdata_b, exp_rd);
        chk({tag, "_flt"}, 32'((sel == 0) ? rsp_fault_a : rsp_fault_b), 32'(exp_flt));
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdy"}, 32'(rdy1), 32'(exp_rdy));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_valid_a", 32'(rsp_valid_a), 32'd0);
        chk("rst_rdata_a", rsp_rdata_a, 32'd0);
        chk("rst_fault_a", 32'(rsp_fault_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready_a", 32'(ready_a), 32'd1);
        chk("post_rst_ready_b", 32'(ready_b), 32'd1);

        // Word store then back-to-back load
        acc(0, "sw10", 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, 1);
        acc(0, "lw10", 0, SZ_W, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, 1);

        // Byte lane write and load extension
        acc(0, "sw20", 1, SZ_W, 0, 32'h20, 32'h0, 0, 32'h0, 1, 1);
        acc(0, "sb21", 1, SZ_B, 0, 32'h21, 32'h12345680, 0, 32'h0, 1, 1);
        acc(0, "lb21", 0, SZ_B, 0, 32'h21, 32'h0, 0, 32'hFFFFFF80, 1, 1);
        acc(0, "lbu21", 0, SZ_B, 1, 32'h21, 32'h0, 0, 32'h00000080, 1, 1);
        acc(0, "lw20", 0, SZ_W, 0, 32'h20, 32'h0, 0, 32'h00008000, 1, 1);

        // Halfword lanes
        acc(0, "sw30", 1, SZ_W, 0, 32'h30, 32'h0, 0, 32'h0, 1, 1);
        acc(0, "sh32", 1, SZ_H, 0, 32'h32, 32'h00008001, 0, 32'h0, 1, 1);
        acc(0, "lh32", 0, SZ_H, 0, 32'h32, 32'h0, 0, 32'hFFFF8001, 1, 1);
        acc(0, "lhu32", 0, SZ_H, 1, 32'h32, 32'h0, 0, 32'h00008001, 1, 1);
        acc(0, "lw30", 0, SZ_W, 0, 32'h30, 32'h0, 0, 32'h80010000, 1, 1);

        // Boundary-crossing split on the misaligned-capable controller
        acc(0, "sw0c", 1, SZ_W, 0, 32'h0C, 32'hAAAAAAAA, 0, 32'h0, 1, 1);
        acc(0, "sw10b", 1, SZ_W, 0, 32'h10, 32'hBBBBBBBB, 0, 32'h0, 1, 1);
        acc(0, "sw0e", 1, SZ_W, 0, 32'h0E, 32'h11223344, 0, 32'h0, 2, 0);
        acc(0, "lw0e", 0, SZ_W, 0, 32'h0E, 32'h0, 0, 32'h11223344, 2, 0);
        acc(0, "lw0c", 0, SZ_W, 0, 32'h0C, 32'h0, 0, 32'h3344AAAA, 1, 1);
        acc(0, "lw10c", 0, SZ_W, 0, 32'h10, 32'h0, 0, 32'hBBBB1122, 1, 1);
        acc(0, "lh0f", 0, SZ_H, 0, 32'h0F, 32'h0, 0, 32'h00002233, 2, 0);

        // Range and encoding faults, no write, no split
        acc(0, "lw1000", 0, SZ_W, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 1);
        acc(0, "sx20", 1, SZ_X, 0, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1, 1);
        acc(0, "lw20b", 0, SZ_W, 0, 32'h20, 32'h0, 0, 32'h00008000, 1, 1);
        acc(0, "lwffe", 0, SZ_W, 0, 32'hFFE, 32'h0, 1, 32'h0, 1, 1);

        // Misaligned faults on the strict controller
        acc(1, "b_sw00", 1, SZ_W, 0, 32'h00, 32'h55667788, 0, 32'h0, 1, 1);
        acc(1, "b_lh03", 0, SZ_H, 0, 32'h03, 32'h0, 1, 32'h0, 1, 1);
        acc(1, "b_sw02", 1, SZ_W, 0, 32'h02, 32'hFFFFFFFF, 1, 32'h0, 1, 1);
        acc(1, "b_lw00", 0, SZ_W, 0, 32'h00, 32'h0, 0, 32'h55667788, 1, 1);
        acc(1, "b_lh02", 0, SZ_H, 0, 32'h02, 32'h0, 0, 32'h00005566, 1, 1);

        // Reset in the middle of a split store
        acc(0, "sw40", 1, SZ_W, 0, 32'h40, 32'h0, 0, 32'h0, 1, 1);
        acc(0, "sw44", 1, SZ_W, 0, 32'h44, 32'h0, 0, 32'h0, 1, 1);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h42; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rs_split_ready", 32'(ready_a), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rs_valid1", 32'(rsp_valid_a), 32'd0);
        chk("rs_ready1", 32'(ready_a), 32'd0);
        @(posedge clk); #1;
        chk("rs_valid2", 32'(rsp_valid_a), 32'd0);
        chk("rs_rdata2", rsp_rdata_a, 32'd0);
        chk("rs_fault2", 32'(rsp_fault_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rs_ready_after", 32'(ready_a), 32'd1);
        chk("rs_valid_after", 32'(rsp_valid_a), 32'd0);
        acc(0, "lw40", 0, SZ_W, 0, 32'h40, 32'h0, 0, 32'hF00D0000, 1, 1);
        acc(0, "lw44", 0, SZ_W, 0, 32'h44, 32'h0, 0, 32'h00000000, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
